// File: rtl/fft_pkg.sv
// Shared FFT definitions: reorder FSM states, bit-reversal helper and the
// default frame geometry used by the reorder stage and the butterfly stages.
package fft_pkg;

   localparam int FFT_N_POINTS = 8;
   localparam int FFT_M        = 8;

   // Widest index the bit-reversal helper handles (frames up to 65536 points).
   localparam int BITREV_W = 16;

   typedef enum logic {
      LOAD  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // Reverse the low log2n bits of idx; bits above log2n come back as zero.
   function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] idx,
                                                  input int                  log2n);
      logic [BITREV_W-1:0] r;
      logic [BITREV_W-1:0] sh;
      r = '0;
      for (int i = 0; i < BITREV_W; i++) begin
         if (i < log2n) begin
            sh = idx >> (log2n - 1 - i);
            r  = r | ({{(BITREV_W-1){1'b0}}, sh[0]} << i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_sample_buf.sv
// Frame sample store: N_POINTS x M registers, one synchronous write port and
// one asynchronous read port. Storage is never reset; the controller only
// reads locations written during the current frame.
module fft_sample_buf #(
   parameter int N_POINTS = 8,
   parameter int M        = 8,
   parameter int LOG2N    = $clog2(N_POINTS)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [LOG2N-1:0] wr_addr,
   input  logic [M-1:0]     wr_data,
   input  logic [LOG2N-1:0] rd_addr,
   output logic [M-1:0]     rd_data
);

   logic [M-1:0] mem [N_POINTS];

   // Capture the incoming sample at its natural-order address.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_reorder_ctrl.sv
// FFT input reorder stage: loads one frame in natural order, then drains it
// in bit-reversed order. Single buffer, so load and drain strictly alternate.
module fft_reorder_ctrl
   import fft_pkg::*;
#(
   parameter int N_POINTS = FFT_N_POINTS,
   parameter int M        = FFT_M
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [M-1:0] in_data,
   input  logic         in_last,
   output logic         in_ready,
   output logic         out_valid,
   output logic [M-1:0] out_data,
   output logic         out_last,
   input  logic         out_ready,
   output logic         busy,
   output logic         frame_err
);

   localparam int               LOG2N = $clog2(N_POINTS);
   localparam logic [LOG2N-1:0] LAST  = LOG2N'(N_POINTS - 1);

   state_t           state, state_nxt;
   logic [LOG2N-1:0] wr_cnt, wr_cnt_nxt;
   logic [LOG2N-1:0] rd_cnt, rd_cnt_nxt;
   logic             err_nxt;
   logic             wr_en;
   logic [LOG2N-1:0] rd_addr;

   assign rd_addr = LOG2N'(bitrev(BITREV_W'(rd_cnt), LOG2N));

   fft_sample_buf #(
      .N_POINTS (N_POINTS),
      .M        (M),
      .LOG2N    (LOG2N)
   ) u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_cnt),
      .wr_data (in_data),
      .rd_addr (rd_addr),
      .rd_data (out_data)
   );

   // State, counters and the registered framing-error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= LOAD;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         wr_cnt    <= wr_cnt_nxt;
         rd_cnt    <= rd_cnt_nxt;
         frame_err <= err_nxt;
      end
   end

   // Next-state, counter update and handshake outputs for the load/drain FSM.
   always_comb begin
      state_nxt  = state;
      wr_cnt_nxt = wr_cnt;
      rd_cnt_nxt = rd_cnt;
      err_nxt    = 1'b0;
      wr_en      = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      busy       = 1'b0;
      unique case (state)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wr_en = 1'b1;
               if (wr_cnt == LAST) begin
                  // Full frame: drain it even if in_last was missing.
                  wr_cnt_nxt = '0;
                  state_nxt  = DRAIN;
                  err_nxt    = ~in_last;
               end else if (in_last) begin
                  // Short frame: drop it and restart at address 0.
                  wr_cnt_nxt = '0;
                  err_nxt    = 1'b1;
               end else begin
                  wr_cnt_nxt = wr_cnt + 1'b1;
               end
            end
         end
         DRAIN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_last  = (rd_cnt == LAST);
            if (out_ready) begin
               if (rd_cnt == LAST) begin
                  rd_cnt_nxt = '0;
                  state_nxt  = LOAD;
               end else begin
                  rd_cnt_nxt = rd_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = LOAD;
      endcase
   end

endmodule

// File: tb/tb_fft_reorder_ctrl.sv
// Directed bench for fft_reorder_ctrl with N_POINTS=8, M=8.
module tb_fft_reorder_ctrl;

   localparam int N = 8;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_last;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         out_ready;
   logic         busy;
   logic         frame_err;

   int n_cmp = 0;
   int n_err = 0;

   // Bit-reversed read order for an 8-point frame, written out by hand.
   int order [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   fft_reorder_ctrl #(.N_POINTS(N), .M(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Push n samples base..base+n-1; in_last on the final one if with_last.
   task automatic send_frame(input int base, input int n, input bit with_last, input bit exp_err);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = W'(base + i);
         in_last  = with_last && (i == n - 1);
         chk("load_in_ready", 32'(in_ready), 1);
         chk("load_out_valid", 32'(out_valid), 0);
         step();
         if (i < n - 1) chk("load_frame_err", 32'(frame_err), 0);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("frame_err_after_last", 32'(frame_err), 32'(exp_err));
      chk("first_out_valid", 32'(out_valid), (n == N) ? 1 : 0);
   endtask

   // Drain one frame; ready_mode 0 = always ready, 1 = ready on odd cycles.
   task automatic drain(input int base, input int ready_mode, input int exp_cycles);
      int k   = 0;
      int cyc = 0;
      while (k < N && cyc < 40) begin
         out_ready = (ready_mode == 0) ? 1'b1 : cyc[0];
         in_valid  = 1'b1;
         in_data   = 8'hEE;
         chk("drain_out_valid", 32'(out_valid), 1);
         chk("drain_busy", 32'(busy), 1);
         chk("drain_in_ready", 32'(in_ready), 0);
         chk("drain_out_data", 32'(out_data), 32'(W'(base + order[k])));
         chk("drain_out_last", 32'(out_last), (k == N - 1) ? 1 : 0);
         if (cyc > 0) chk("drain_frame_err", 32'(frame_err), 0);
         step();
         if (out_ready) k++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("drain_count", 32'(k), N);
      chk("drain_cycles", 32'(cyc), 32'(exp_cycles));
      chk("post_in_ready", 32'(in_ready), 1);
      chk("post_out_valid", 32'(out_valid), 0);
      chk("post_busy", 32'(busy), 0);
   endtask

   initial begin
      int got_q[$];
      int last_q[$];
      int idx;
      int cyc;
      int exp_v;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_frame_err", 32'(frame_err), 0);
      rst = 1'b0;
      step();

      // Plain frame, always ready.
      send_frame(10, 8, 1'b1, 1'b0);
      drain(10, 0, 8);

      // Same frame with a stalling consumer.
      send_frame(10, 8, 1'b1, 1'b0);
      drain(10, 1, 16);

      // Short frame is dropped, next full frame is intact.
      send_frame(90, 5, 1'b1, 1'b1);
      step();
      chk("short_err_clears", 32'(frame_err), 0);
      chk("short_no_out_valid", 32'(out_valid), 0);
      chk("short_in_ready", 32'(in_ready), 1);
      send_frame(20, 8, 1'b1, 1'b0);
      drain(20, 0, 8);

      // Missing in_last on the eighth sample.
      send_frame(30, 8, 1'b0, 1'b1);
      drain(30, 0, 8);

      // Reset in the middle of a drain.
      send_frame(50, 8, 1'b1, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("pre_rst_out_data", 32'(out_data), 32'(W'(50 + order[i])));
         step();
      end
      out_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_in_ready", 32'(in_ready), 1);
      chk("midrst_busy", 32'(busy), 0);
      step();
      rst = 1'b0;
      step();
      chk("postrst_out_valid", 32'(out_valid), 0);
      send_frame(40, 8, 1'b1, 1'b0);
      drain(40, 0, 8);

      // Back-to-back frames 60..67 and 70..77 with the source always offering.
      idx       = 0;
      cyc       = 0;
      out_ready = 1'b1;
      while (got_q.size() < 16 && cyc < 80) begin
         in_valid = (idx < 16);
         in_data  = (idx < 8) ? W'(60 + idx) : W'(70 + idx - 8);
         in_last  = (idx % 8 == 7);
         if (busy) chk("b2b_in_ready_drain", 32'(in_ready), 0);
         if (out_valid) begin
            got_q.push_back(int'(out_data));
            last_q.push_back(int'(out_last));
         end
         step();
         if (in_valid && !busy) idx++;
         cyc++;
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      chk("b2b_out_count", 32'(got_q.size()), 16);
      chk("b2b_in_count", 32'(idx), 16);
      for (int j = 0; j < 16 && j < got_q.size(); j++) begin
         exp_v = ((j < 8) ? 60 : 70) + order[j % 8];
         chk("b2b_out_data", 32'(got_q[j]), 32'(exp_v));
         chk("b2b_out_last", 32'(last_q[j]), (j % 8 == 7) ? 1 : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
